// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, sequencer states and opcode classification helpers.
// Used by alu_op_decode and alu_op_sequencer (and the ALU datapath itself).
package alu_pkg;

  localparam int NUM_OPS = 13;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // Bit positions inside the one-hot strobe vector
  localparam int IDX_ADD  = 0;
  localparam int IDX_SUB  = 1;
  localparam int IDX_MUL  = 2;
  localparam int IDX_DIV  = 3;
  localparam int IDX_AND  = 4;
  localparam int IDX_OR   = 5;
  localparam int IDX_SHR  = 6;
  localparam int IDX_SHRA = 7;
  localparam int IDX_SHL  = 8;
  localparam int IDX_ROR  = 9;
  localparam int IDX_ROL  = 10;
  localparam int IDX_NEG  = 11;
  localparam int IDX_NOT  = 12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_YLOAD = 3'd1,
    S_EXEC  = 3'd2,
    S_WBLO  = 3'd3,
    S_WBHI  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  function automatic logic [NUM_OPS-1:0] op_onehot(input logic [4:0] op);
    logic [NUM_OPS-1:0] v;
    v = '0;
    case (op)
      OP_ADD:  v[IDX_ADD]  = 1'b1;
      OP_SUB:  v[IDX_SUB]  = 1'b1;
      OP_SHR:  v[IDX_SHR]  = 1'b1;
      OP_SHRA: v[IDX_SHRA] = 1'b1;
      OP_SHL:  v[IDX_SHL]  = 1'b1;
      OP_ROR:  v[IDX_ROR]  = 1'b1;
      OP_ROL:  v[IDX_ROL]  = 1'b1;
      OP_AND:  v[IDX_AND]  = 1'b1;
      OP_OR:   v[IDX_OR]   = 1'b1;
      OP_MUL:  v[IDX_MUL]  = 1'b1;
      OP_DIV:  v[IDX_DIV]  = 1'b1;
      OP_NEG:  v[IDX_NEG]  = 1'b1;
      OP_NOT:  v[IDX_NOT]  = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: one-hot ALU strobe vector plus illegal/unary/muldiv flags.
// Opcode bits above the 5-bit map must be zero for the opcode to be legal (OPW >= 5).
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0]     opcode,
  output logic [NUM_OPS-1:0] strobes,
  output logic               illegal,
  output logic               unary,
  output logic               muldiv
);

  logic                upper_zero;
  logic [NUM_OPS-1:0]  onehot;

  generate
    if (OPW > 5) begin : g_wide
      assign upper_zero = ~|opcode[OPW-1:5];
    end else begin : g_narrow
      assign upper_zero = 1'b1;
    end
  endgenerate

  assign onehot  = op_onehot(opcode[4:0]);
  assign strobes = upper_zero ? onehot : '0;
  assign illegal = ~|strobes;
  assign unary   = upper_zero & is_unary(opcode[4:0]);
  assign muldiv  = upper_zero & is_muldiv(opcode[4:0]);

endmodule

// File: rtl/alu_op_sequencer.sv
// Control sequencer in front of the 32-bit ALU: Y load, op strobe with Z capture, Z writeback.
// Optional macro ALU_OP_SEQ_BACK2BACK_EN accepts a new start during the done cycle.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int OPW                = 5,
  parameter int EXEC_CYCLES        = 1,
  parameter int MULDIV_EXEC_CYCLES = 1
) (
  input  logic           clock,
  input  logic           clear_n,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  output logic           busy,
  output logic           done,
  output logic           illegal,
  output logic           src1_out,
  output logic           src2_out,
  output logic           Yin,
  output logic           Zin,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           Rin,
  output logic           LOin,
  output logic           HIin,
  output logic           op_add,
  output logic           op_sub,
  output logic           op_mul,
  output logic           op_div,
  output logic           op_and,
  output logic           op_or,
  output logic           op_shr,
  output logic           op_shra,
  output logic           op_shl,
  output logic           op_ror,
  output logic           op_rol,
  output logic           op_neg,
  output logic           op_not
);

  localparam int MAX_N = (EXEC_CYCLES > MULDIV_EXEC_CYCLES) ? EXEC_CYCLES : MULDIV_EXEC_CYCLES;
  localparam int CW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [CW-1:0] LAST_STD = CW'(EXEC_CYCLES - 1);
  localparam logic [CW-1:0] LAST_MD  = CW'(MULDIV_EXEC_CYCLES - 1);

  state_t             state, state_nxt, entry_state;
  logic [OPW-1:0]     op_q;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               accept, last_exec;
  logic               in_upper_zero, in_legal;
  logic [NUM_OPS-1:0] cap_strobes, op_strobes;
  logic               cap_illegal, cap_unary, cap_muldiv;
  logic               unused_cap;

  alu_op_decode #(.OPW(OPW)) u_dec (
    .opcode  (op_q),
    .strobes (cap_strobes),
    .illegal (cap_illegal),
    .unary   (cap_unary),
    .muldiv  (cap_muldiv)
  );

  assign unused_cap = &{1'b0, cap_illegal, cap_unary};

  // Classification of the live opcode, needed only to pick the first state on accept
  generate
    if (OPW > 5) begin : g_in_wide
      assign in_upper_zero = ~|opcode[OPW-1:5];
    end else begin : g_in_narrow
      assign in_upper_zero = 1'b1;
    end
  endgenerate

  assign in_legal = in_upper_zero & (|op_onehot(opcode[4:0]));

  always_comb begin
    entry_state = S_YLOAD;
    if (!in_legal)
      entry_state = S_ERR;
    else if (is_unary(opcode[4:0]))
      entry_state = S_EXEC;
  end

`ifdef ALU_OP_SEQ_BACK2BACK_EN
  logic done_state;
  assign done_state = ((state == S_WBLO) && !cap_muldiv) || (state == S_WBHI);
  assign accept     = start && ((state == S_IDLE) || done_state);
`else
  assign accept     = start && (state == S_IDLE);
`endif

  assign last_exec = (cnt == (cap_muldiv ? LAST_MD : LAST_STD));

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept)
        op_q <= opcode;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      S_IDLE:  if (accept) state_nxt = entry_state;
      S_YLOAD: state_nxt = S_EXEC;
      S_EXEC: begin
        if (last_exec)
          state_nxt = S_WBLO;
        else
          cnt_nxt = cnt + CW'(1);
      end
      S_WBLO: begin
        if (cap_muldiv)
          state_nxt = S_WBHI;
        else if (accept)
          state_nxt = entry_state;
        else
          state_nxt = S_IDLE;
      end
      S_WBHI:  state_nxt = accept ? entry_state : S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    done       = 1'b0;
    illegal    = 1'b0;
    src1_out   = 1'b0;
    src2_out   = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    Rin        = 1'b0;
    LOin       = 1'b0;
    HIin       = 1'b0;
    op_strobes = '0;
    case (state)
      S_YLOAD: begin
        src1_out = 1'b1;
        Yin      = 1'b1;
      end
      S_EXEC: begin
        src2_out   = 1'b1;
        op_strobes = cap_strobes;
        Zin        = last_exec;
      end
      S_WBLO: begin
        Zlowout = 1'b1;
        LOin    = cap_muldiv;
        Rin     = ~cap_muldiv;
        done    = ~cap_muldiv;
      end
      S_WBHI: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
      S_ERR:   illegal = 1'b1;
      default: ;
    endcase
  end

  assign op_add  = op_strobes[IDX_ADD];
  assign op_sub  = op_strobes[IDX_SUB];
  assign op_mul  = op_strobes[IDX_MUL];
  assign op_div  = op_strobes[IDX_DIV];
  assign op_and  = op_strobes[IDX_AND];
  assign op_or   = op_strobes[IDX_OR];
  assign op_shr  = op_strobes[IDX_SHR];
  assign op_shra = op_strobes[IDX_SHRA];
  assign op_shl  = op_strobes[IDX_SHL];
  assign op_ror  = op_strobes[IDX_ROR];
  assign op_rol  = op_strobes[IDX_ROL];
  assign op_neg  = op_strobes[IDX_NEG];
  assign op_not  = op_strobes[IDX_NOT];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: per-cycle output traces versus a trace-level model.
// Honours ALU_OP_SEQ_BACK2BACK_EN for the back-to-back expectation.
module tb_alu_op_sequencer;

  localparam int EXEC_N = 1;
  localparam int MD_N   = 4;

  // Observed vector bit positions
  localparam int B_BUSY = 24, B_DONE = 23, B_ILL = 22, B_SRC1 = 21, B_SRC2 = 20;
  localparam int B_YIN = 19, B_ZIN = 18, B_ZLO = 17, B_ZHI = 16, B_RIN = 15;
  localparam int B_LOIN = 14, B_HIIN = 13;

  logic clock = 1'b0;
  logic clear_n = 1'b0;
  logic start = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic busy, done, illegal, src1_out, src2_out, Yin, Zin, Zlowout, Zhighout, Rin, LOin, HIin;
  logic op_add, op_sub, op_mul, op_div, op_and, op_or, op_shr, op_shra, op_shl, op_ror, op_rol;
  logic op_neg, op_not;
  logic [24:0] obs;

  int compared = 0;
  int mismatched = 0;
  logic [24:0] exp_q[$];
  logic [24:0] obs_q[$];

  alu_op_sequencer #(.OPW(5), .EXEC_CYCLES(EXEC_N), .MULDIV_EXEC_CYCLES(MD_N)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .opcode(opcode),
    .busy(busy), .done(done), .illegal(illegal), .src1_out(src1_out), .src2_out(src2_out),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .Rin(Rin),
    .LOin(LOin), .HIin(HIin),
    .op_add(op_add), .op_sub(op_sub), .op_mul(op_mul), .op_div(op_div), .op_and(op_and),
    .op_or(op_or), .op_shr(op_shr), .op_shra(op_shra), .op_shl(op_shl), .op_ror(op_ror),
    .op_rol(op_rol), .op_neg(op_neg), .op_not(op_not)
  );

  always #5 clock = ~clock;

  assign obs = {busy, done, illegal, src1_out, src2_out, Yin, Zin, Zlowout, Zhighout, Rin,
                LOin, HIin, op_add, op_sub, op_mul, op_div, op_and, op_or, op_shr, op_shra,
                op_shl, op_ror, op_rol, op_neg, op_not};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Strobe bit for each legal opcode, -1 when the opcode is outside the map
  function automatic int op_bit(input logic [4:0] op);
    case (op)
      5'b00011: return 12; // add
      5'b00100: return 11; // sub
      5'b01111: return 10; // mul
      5'b10000: return 9;  // div
      5'b01010: return 8;  // and
      5'b01011: return 7;  // or
      5'b00101: return 6;  // shr
      5'b00110: return 5;  // shra
      5'b00111: return 4;  // shl
      5'b01000: return 3;  // ror
      5'b01001: return 2;  // rol
      5'b10001: return 1;  // neg
      5'b10010: return 0;  // not
      default:  return -1;
    endcase
  endfunction

  task automatic push_trace(input logic [4:0] op);
    int b;
    int n;
    logic [24:0] v;
    bit unary, md;
    b = op_bit(op);
    if (b < 0) begin
      v = '0; v[B_BUSY] = 1; v[B_ILL] = 1;
      exp_q.push_back(v);
      return;
    end
    unary = (op == 5'b10001) || (op == 5'b10010);
    md    = (op == 5'b01111) || (op == 5'b10000);
    n     = md ? MD_N : EXEC_N;
    if (!unary) begin
      v = '0; v[B_BUSY] = 1; v[B_SRC1] = 1; v[B_YIN] = 1;
      exp_q.push_back(v);
    end
    for (int i = 0; i < n; i++) begin
      v = '0; v[B_BUSY] = 1; v[B_SRC2] = 1; v[b] = 1; v[B_ZIN] = (i == n - 1);
      exp_q.push_back(v);
    end
    if (md) begin
      v = '0; v[B_BUSY] = 1; v[B_ZLO] = 1; v[B_LOIN] = 1;
      exp_q.push_back(v);
      v = '0; v[B_BUSY] = 1; v[B_ZHI] = 1; v[B_HIIN] = 1; v[B_DONE] = 1;
      exp_q.push_back(v);
    end else begin
      v = '0; v[B_BUSY] = 1; v[B_ZLO] = 1; v[B_RIN] = 1; v[B_DONE] = 1;
      exp_q.push_back(v);
    end
  endtask

  // Pulse start for one cycle, then scramble opcode and record ncyc output samples
  task automatic drive_op(input logic [4:0] op, input int ncyc);
    obs_q.delete();
    @(negedge clock);
    start = 1'b1;
    opcode = op;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      if (i == 0) begin
        start = 1'b0;
        opcode = 5'($urandom);
      end
      obs_q.push_back(obs);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    compared++;
    if (obs !== 25'd0) begin
      mismatched++;
      $display("FAIL reset_hold: outputs %b, required all zero", obs);
    end
    clear_n = 1'b1;
    @(negedge clock);
    compared++;
    if (obs !== 25'd0) begin
      mismatched++;
      $display("FAIL reset_release: outputs %b, required all zero", obs);
    end
  endtask

  task automatic test_op(input logic [4:0] op, input string name);
    exp_q.delete();
    push_trace(op);
    exp_q.push_back('0);
    drive_op(op, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      compared++;
      if (obs_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL %s op=%b cyc%0d: got %b, required %b", name, op, i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [4:0] op;
    for (int k = 0; k < 40; k++) begin
      op = 5'($urandom_range(0, 31));
      exp_q.delete();
      push_trace(op);
      exp_q.push_back('0);
      drive_op(op, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        compared++;
        if (obs_q[i] !== exp_q[i]) begin
          mismatched++;
          $display("FAIL random op=%b cyc%0d: got %b, required %b", op, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [24:0] e;
    int dones;
    @(negedge clock);
    start = 1'b1;
    opcode = 5'b10000;
    @(negedge clock);
    start = 1'b0;
    e = '0; e[B_BUSY] = 1; e[B_SRC1] = 1; e[B_YIN] = 1;
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL midrst_yload: got %b, required %b", obs, e);
    end
    @(negedge clock);
    e = '0; e[B_BUSY] = 1; e[B_SRC2] = 1; e[9] = 1;
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL midrst_exec: got %b, required %b", obs, e);
    end
    #1 clear_n = 1'b0;
    #1;
    compared++;
    if (obs !== 25'd0) begin
      mismatched++;
      $display("FAIL midrst_drop: got %b, required all zero", obs);
    end
    @(negedge clock);
    clear_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      dones += int'(done);
      compared++;
      if (obs !== 25'd0) begin
        mismatched++;
        $display("FAIL midrst_after cyc%0d: got %b, required all zero", i, obs);
      end
    end
    compared++;
    if (dones != 0) begin
      mismatched++;
      $display("FAIL midrst_done_count: got %0d, required 0", dones);
    end
  endtask

  task automatic test_back_to_back;
    int yloads;
    exp_q.delete();
    push_trace(5'b00100);
`ifndef ALU_OP_SEQ_BACK2BACK_EN
    exp_q.push_back('0);
`endif
    push_trace(5'b00100);
    exp_q.push_back('0);
    @(negedge clock);
    start = 1'b1;
    opcode = 5'b00100;
    yloads = 0;
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      obs_q.push_back(obs);
      if (Yin) yloads++;
      if (yloads == 2) start = 1'b0;
    end
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      compared++;
      if (obs_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL back_to_back cyc%0d: got %b, required %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_op(5'b00011, "add");
    test_op(5'b10010, "not");
    test_op(5'b01111, "mul");
    test_op(5'b11111, "illegal");
    test_op(5'b10000, "div");
    test_op(5'b10001, "neg");
    test_random();
    test_reset_mid();
    test_op(5'b00011, "add_after_reset");
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control stage directly upstream of the 32-bit ALU datapath.
- Accepts a 5-bit ALU opcode on a start pulse and sequences the operand/result transfers around the ALU: Y-register load, ALU op strobe with Z capture, then Z-to-register writeback.
- Drives the ALU's one-hot op inputs (ADD..NOT, IncPC unused here), plus the Yin/Zin/Zlowout/Zhighout/Rin/HIin/LOin bus strobes.

Parameters:
- OPW, 5, opcode width.
- EXEC_CYCLES, 1, cycles the ALU op strobe is held for all non-MUL/DIV ops (≥1).
- MULDIV_EXEC_CYCLES, 1, cycles the ALU op strobe is held for MUL/DIV (≥1).

Ports:
- clock  in  1  single clock, all state on rising edge
- clear_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- opcode  in  OPW  ALU opcode, captured with accepted start
- busy  out  1  high from cycle after accept until sequence ends
- done  out  1  one-cycle pulse on final writeback cycle
- illegal  out  1  one-cycle pulse when an unknown opcode is accepted
- src1_out  out  1  first source register drives bus
- src2_out  out  1  second (or sole) source register drives bus
- Yin  out  1  Y register load
- Zin  out  1  Z (64-bit) register load
- Zlowout  out  1  Zlow drives bus
- Zhighout  out  1  Zhigh drives bus
- Rin  out  1  destination register load
- LOin  out  1  LO register load
- HIin  out  1  HI register load
- op_add, op_sub, op_mul, op_div, op_and, op_or, op_shr, op_shra, op_shl, op_ror, op_rol, op_neg, op_not  out  1 each  one-hot ALU op strobes

Behaviour:
- Opcode map: ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010. All others are illegal.
- Reset (clear_n=0, async): state IDLE, counter 0, captured opcode 0; every output 0.
- States: IDLE, YLOAD, EXEC, WBLO, WBHI, ERR.
- IDLE:
  - start=1 with a binary opcode → YLOAD.
  - start=1 with NEG/NOT → EXEC (Y skipped).
  - start=1 with an illegal opcode → ERR.
  - start=0 → stay.
- YLOAD (1 cycle): src1_out=1, Yin=1 → EXEC.
- EXEC:
  - Held for N cycles: N=MULDIV_EXEC_CYCLES for MUL/DIV, else EXEC_CYCLES.
  - src2_out=1 and the decoded op strobe=1 on every EXEC cycle.
  - Zin=1 only on the final EXEC cycle.
  - Counter counts 0..N-1, then resets to 0 → WBLO.
- WBLO (1 cycle): Zlowout=1.
  - MUL/DIV: LOin=1 → WBHI.
  - Otherwise: Rin=1, done=1 → IDLE.
- WBHI (1 cycle): Zhighout=1, HIin=1, done=1 → IDLE.
- ERR (1 cycle): illegal=1, no strobes, no done → IDLE.
- busy=1 in every non-IDLE state. start while busy is ignored (except per Optional Feature).
- Op strobes are never asserted outside EXEC. At most one op strobe is high in any cycle.
- Latency, accept edge to done cycle:
  - binary op: 1+N+1 cycles
  - NEG/NOT: N+1 cycles
  - MUL/DIV: 1+N+2 cycles
- opcode input changes after accept have no effect. The captured copy is used throughout.
- clear_n asserted mid-sequence: all outputs drop immediately and combinationally with reset. No partial writeback is completed. After release the block sits in IDLE.

Optional Feature:
- Macro: ALU_OP_SEQ_BACK2BACK_EN.
- When defined: start=1 during the done cycle (WBLO or WBHI) is accepted. Next state is YLOAD/EXEC/ERR for the new opcode, skipping IDLE, and busy stays high.
- When undefined: start is sampled only in IDLE, so a mandatory IDLE cycle separates sequences.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD..OP_NOT)
  - state enum constants
  - opcode→one-hot decode function
  - is_unary / is_muldiv helper functions
- The ALU module imports the same opcode constants.
- One natural sub-module: alu_op_decode (combinational opcode → one-hot strobe vector + illegal/unary/muldiv flags), instantiated once on the captured opcode.

Test Plan:
- ADD (00011), defaults:
  - Cycle 1: YLOAD (src1_out, Yin).
  - Cycle 2: EXEC (src2_out, op_add, Zin).
  - Cycle 3: WBLO (Zlowout, Rin, done).
  - busy high cycles 1–3.
- NOT (10010): YLOAD skipped; EXEC with op_not+Zin, then WBLO with Rin+done. Total 2 cycles, Yin never asserted.
- MUL (01111) with MULDIV_EXEC_CYCLES=4:
  - op_mul high 4 cycles, Zin only on the 4th.
  - WBLO asserts LOin (not Rin).
  - WBHI asserts Zhighout+HIin+done.
  - Total 7 cycles.
- Illegal opcode 11111: one ERR cycle with illegal=1 and no strobes, no done; returns to IDLE.
- Reset mid-sequence: clear_n low during DIV EXEC → all outputs 0 same cycle. After release, no done; the next ADD request runs normally.
- Back-to-back, start held high across two SUB requests:
  - Without ALU_OP_SEQ_BACK2BACK_EN: one IDLE gap between the two done pulses.
  - With it: the second YLOAD immediately follows the first WBLO, and busy never drops.
